regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bits per register.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width; depth = 2**ADDR_WIDTH.
REQ-003 Parameter NUM_RD, default 2, number of read ports.
REQ-004 Parameter NUM_WR, default 2, number of write ports.
REQ-005 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding enabled.
REQ-006 Parameter ZERO_REG, default 1, 1 = register 0 hardwired to zero and never busy.
REQ-007 clk_i  input  1  positive-edge clock.
REQ-008 rst_ni  input  1  reset, asynchronous, active-low.
REQ-009 rd_addr_i  input  NUM_RD*ADDR_WIDTH  packed read addresses, port r at slice r.
REQ-010 rd_data_o  output  NUM_RD*DATA_WIDTH  packed read data.
REQ-011 rd_busy_o  output  NUM_RD  scoreboard busy bit of each addressed register.
REQ-012 wr_en_i  input  NUM_WR  per-port write enable.
REQ-013 wr_addr_i  input  NUM_WR*ADDR_WIDTH  packed write addresses.
REQ-014 wr_data_i  input  NUM_WR*DATA_WIDTH  packed write data.
REQ-015 busy_set_i  input  1  mark register busy_addr_i pending.
REQ-016 busy_addr_i  input  ADDR_WIDTH  register to mark busy.
REQ-017 clr_i  input  1  start clear sweep.
REQ-018 ready_o  output  1  1 = IDLE, writes and busy_set accepted.

Function
REQ-019 Writes SHALL commit at posedge clk_i for each port with wr_en_i set, in state IDLE only.
REQ-020 Same-address write conflict: highest-index write port SHALL win.
REQ-021 With ZERO_REG=1, writes to address 0 SHALL be dropped; reads of address 0 SHALL return 0.
REQ-022 Reads SHALL be combinational from the array, zero-cycle latency.
REQ-023 With BYPASS=1 in IDLE, a read whose address matches an enabled, committing write SHALL return that write's data (highest-index port on conflict); with BYPASS=0, old contents.
REQ-024 busy_set_i in IDLE SHALL set busy[busy_addr_i] at the next edge; a committing write SHALL clear busy[wr_addr].
REQ-025 Simultaneous busy set and write-clear to the same address: set SHALL win.
REQ-026 rd_busy_o[r] SHALL equal the registered busy bit of rd_addr r (no forwarding); address 0 always 0 with ZERO_REG=1.
REQ-027 FSM states IDLE, SWEEP; IDLE->SWEEP when clr_i=1 in IDLE; SWEEP->IDLE after index 2**ADDR_WIDTH-1 is cleared.
REQ-028 SWEEP: ADDR_WIDTH-bit counter starts at 0, each cycle zeroes mem[idx] and busy[idx], increments; sweep lasts exactly 2**ADDR_WIDTH cycles.
REQ-029 SWEEP: ready_o=0; writes, busy_set_i and clr_i SHALL be ignored; reads return array contents with bypass disabled.
REQ-030 ready_o SHALL be 1 in IDLE, including the cycle clr_i is sampled.

Reset
REQ-031 rst_ni low SHALL immediately force all registers to 0, all busy bits to 0, state IDLE, sweep counter 0, ready_o=1.
REQ-032 Reset asserted mid-SWEEP SHALL abort the sweep; block resumes in IDLE with all entries zero.

Verification
REQ-033 Write port0 x5=0x1234, next cycle read port1 x5 -> 0x1234; same-cycle read with BYPASS=1 -> 0x1234, BYPASS=0 -> 0.
REQ-034 Port0 and port1 both write x7 (0xAAAA, 0xBBBB) same cycle -> read x7 = 0xBBBB; write 0xFFFF to x0 -> read x0 = 0.
REQ-035 busy_set x3, next cycle rd_busy_o=1 for x3; write x3 -> busy 0 next cycle; set and write x3 same cycle -> busy stays 1.
REQ-036 Fill x1..x31 nonzero, pulse clr_i -> ready_o=0 for 32 cycles, writes during sweep dropped, then ready_o=1 and all reads 0.
REQ-037 Assert rst_ni low at sweep cycle 10 -> ready_o=1 and all entries 0 immediately, clr_i accepted after release.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with a per-entry busy scoreboard and a clear sweep.
// Writes, busy marking and forwarding are only active while the block is idle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | normal operation: writes, busy_set and forwarding active
// SWEEP | clearing one entry per cycle; writes/busy_set/clr ignored
module regfile_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
   output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
   output logic [NUM_RD-1:0]            rd_busy_o,
   input  logic [NUM_WR-1:0]            wr_en_i,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
   input  logic                         busy_set_i,
   input  logic [ADDR_WIDTH-1:0]        busy_addr_i,
   input  logic                         clr_i,
   output logic                         ready_o
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t                  state, state_nxt;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DEPTH-1:0]        busy;
   logic [ADDR_WIDTH-1:0]   idx;
   logic [ADDR_WIDTH-1:0]   wa [NUM_WR];
   logic [DATA_WIDTH-1:0]   wd [NUM_WR];
   logic [NUM_WR-1:0]       wcommit;
   logic                    bset;
   logic                    idle;

   assign idle    = (state == IDLE);
   assign ready_o = idle;

   for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
      assign wa[w]      = wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH];
      assign wd[w]      = wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
      assign wcommit[w] = wr_en_i[w] && idle && !((ZERO_REG != 0) && (wa[w] == '0));
   end

   assign bset = busy_set_i && idle && !((ZERO_REG != 0) && (busy_addr_i == '0));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clr_i) state_nxt = SWEEP;
         SWEEP:   if (idx == '1) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         if (state == SWEEP) idx <= idx + 1'b1;
         else                idx <= '0;
      end
   end

   // Ascending port order makes the highest-index port win on address conflicts.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (state == SWEEP) begin
         mem[idx] <= '0;
      end else begin
         for (int w = 0; w < NUM_WR; w++)
            if (wcommit[w]) mem[wa[w]] <= wd[w];
      end
   end

   // Set is applied after the write-clears so it wins on the same address.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy <= '0;
      end else if (state == SWEEP) begin
         busy[idx] <= 1'b0;
      end else begin
         for (int w = 0; w < NUM_WR; w++)
            if (wcommit[w]) busy[wa[w]] <= 1'b0;
         if (bset) busy[busy_addr_i] <= 1'b1;
      end
   end

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rdata;

      assign ra = rd_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
         rdata = mem[ra];
         if ((BYPASS != 0) && idle) begin
            for (int w = 0; w < NUM_WR; w++)
               if (wcommit[w] && (wa[w] == ra)) rdata = wd[w];
         end
         if ((ZERO_REG != 0) && (ra == '0)) rdata = '0;
      end

      assign rd_data_o[r*DATA_WIDTH +: DATA_WIDTH] = rdata;
      assign rd_busy_o[r] = busy[ra] && !((ZERO_REG != 0) && (ra == '0));
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a forwarding instance and a non-forwarding
// instance share all inputs so both read behaviours can be checked together.
module tb_regfile_mp;

   logic        clk_sys = 1'b0;
   logic        rst_b;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data, rd_data_nb;
   logic [1:0]  rd_busy, rd_busy_nb;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        busy_set;
   logic [4:0]  busy_addr;
   logic        clr;
   logic        ready, ready_nb;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_sys = ~clk_sys;

   regfile_mp #(.BYPASS(1)) dut (
      .clk_i(clk_sys), .rst_ni(rst_b),
      .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .busy_set_i(busy_set), .busy_addr_i(busy_addr),
      .clr_i(clr), .ready_o(ready)
   );

   regfile_mp #(.BYPASS(0)) dut_nb (
      .clk_i(clk_sys), .rst_ni(rst_b),
      .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb), .rd_busy_o(rd_busy_nb),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .busy_set_i(busy_set), .busy_addr_i(busy_addr),
      .clr_i(clr), .ready_o(ready_nb)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
      wr_en[p]          = en;
      wr_addr[p*5 +: 5] = a;
      wr_data[p*32 +: 32] = d;
   endtask

   task automatic set_rd(input int p, input logic [4:0] a);
      rd_addr[p*5 +: 5] = a;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   initial begin
      int cnt;
      rst_b = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
      busy_set = 1'b0; busy_addr = '0; clr = 1'b0;
      #12;
      check("reset_ready", {31'd0, ready}, 32'd1);
      set_rd(0, 5'd5); #1;
      check("reset_rd_x5", rd_data[31:0], 32'h0);
      check("reset_busy_x5", {31'd0, rd_busy[0]}, 32'd0);
      rst_b = 1'b1;
      tick();

      // write x5 on port 0, read through port 1
      set_wr(0, 1'b1, 5'd5, 32'h1234);
      set_rd(1, 5'd5); #1;
      check("bypass_x5", rd_data[63:32], 32'h1234);
      check("nobypass_x5", rd_data_nb[63:32], 32'h0);
      tick();
      set_wr(0, 1'b0, 5'd0, 32'h0); #1;
      check("read_x5", rd_data[63:32], 32'h1234);
      check("read_x5_nb", rd_data_nb[63:32], 32'h1234);

      // same-address conflict, port 1 wins
      set_wr(0, 1'b1, 5'd7, 32'hAAAA);
      set_wr(1, 1'b1, 5'd7, 32'hBBBB);
      set_rd(0, 5'd7); #1;
      check("bypass_conflict_x7", rd_data[31:0], 32'hBBBB);
      tick();
      set_wr(0, 1'b0, 5'd0, 32'h0);
      set_wr(1, 1'b0, 5'd0, 32'h0); #1;
      check("conflict_x7", rd_data[31:0], 32'hBBBB);
      check("conflict_x7_nb", rd_data_nb[31:0], 32'hBBBB);

      // x0 hardwired
      set_wr(0, 1'b1, 5'd0, 32'hFFFF);
      set_rd(0, 5'd0); #1;
      check("bypass_x0", rd_data[31:0], 32'h0);
      tick();
      set_wr(0, 1'b0, 5'd0, 32'h0); #1;
      check("read_x0", rd_data[31:0], 32'h0);

      // busy scoreboard
      busy_set = 1'b1; busy_addr = 5'd3;
      set_rd(0, 5'd3); set_rd(1, 5'd0); #1;
      check("busy_x3_before", {31'd0, rd_busy[0]}, 32'd0);
      tick();
      busy_set = 1'b0; #1;
      check("busy_x3_set", {31'd0, rd_busy[0]}, 32'd1);
      set_wr(1, 1'b1, 5'd3, 32'h33);
      tick();
      set_wr(1, 1'b0, 5'd0, 32'h0); #1;
      check("busy_x3_cleared", {31'd0, rd_busy[0]}, 32'd0);
      check("data_x3", rd_data[31:0], 32'h33);
      busy_set = 1'b1; busy_addr = 5'd3;
      set_wr(0, 1'b1, 5'd3, 32'h44);
      tick();
      busy_set = 1'b0;
      set_wr(0, 1'b0, 5'd0, 32'h0); #1;
      check("busy_x3_set_wins", {31'd0, rd_busy[0]}, 32'd1);
      busy_set = 1'b1; busy_addr = 5'd0;
      tick();
      busy_set = 1'b0; #1;
      check("busy_x0_never", {31'd0, rd_busy[1]}, 32'd0);

      // fill x1..x31, then sweep
      for (int i = 1; i < 32; i++) begin
         set_wr(0, 1'b1, 5'(i), 32'h01010101 * i);
         tick();
      end
      set_wr(0, 1'b0, 5'd0, 32'h0);
      set_rd(0, 5'd1); set_rd(1, 5'd31); #1;
      check("fill_x1", rd_data[31:0], 32'h01010101);
      check("fill_x31", rd_data[63:32], 32'h1F1F1F1F);
      clr = 1'b1; #1;
      check("ready_at_clr", {31'd0, ready}, 32'd1);
      tick();
      clr = 1'b0;
      set_wr(0, 1'b1, 5'd31, 32'hDEAD);
      set_wr(1, 1'b1, 5'd9, 32'hBEEF);
      busy_set = 1'b1; busy_addr = 5'd4; #1;
      check("sweep_no_bypass", rd_data[63:32], 32'h1F1F1F1F);
      cnt = 0;
      while (!ready && cnt < 40) begin
         cnt++;
         tick();
      end
      set_wr(0, 1'b0, 5'd0, 32'h0);
      set_wr(1, 1'b0, 5'd0, 32'h0);
      busy_set = 1'b0;
      check("sweep_cycles", 32'(cnt), 32'd32);
      for (int i = 0; i < 32; i += 2) begin
         set_rd(0, 5'(i)); set_rd(1, 5'(i + 1)); #1;
         check($sformatf("swept_x%0d", i), rd_data[31:0], 32'h0);
         check($sformatf("swept_x%0d", i + 1), rd_data[63:32], 32'h0);
      end
      set_rd(0, 5'd4); set_rd(1, 5'd3); #1;
      check("sweep_busy_x4", {31'd0, rd_busy[0]}, 32'd0);
      check("sweep_busy_x3", {31'd0, rd_busy[1]}, 32'd0);

      // reset aborting a sweep
      set_wr(0, 1'b1, 5'd31, 32'h5555);
      set_wr(1, 1'b1, 5'd20, 32'h6666);
      tick();
      set_wr(0, 1'b0, 5'd0, 32'h0);
      set_wr(1, 1'b0, 5'd0, 32'h0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      set_rd(0, 5'd31); set_rd(1, 5'd20); #1;
      check("pre_reset_ready", {31'd0, ready}, 32'd0);
      check("pre_reset_x31", rd_data[31:0], 32'h5555);
      rst_b = 1'b0; #1;
      check("abort_ready", {31'd0, ready}, 32'd1);
      check("abort_x31", rd_data[31:0], 32'h0);
      check("abort_x20", rd_data[63:32], 32'h0);
      #2;
      rst_b = 1'b1;
      clr = 1'b1;
      tick();
      clr = 1'b0; #1;
      check("clr_after_reset", {31'd0, ready}, 32'd0);
      cnt = 0;
      while (!ready && cnt < 40) begin
         cnt++;
         tick();
      end
      check("second_sweep_cycles", 32'(cnt), 32'd32);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
